// File: rtl/parity_stream_check.sv
// Parity stream checker: checks the even parity of each incoming word, gathers
// per-frame statistics, and queues finished frame results in a 2-entry FIFO.
module parity_stream_check #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic             out_par,
  output logic [CNT_W-1:0] out_len,
  input  logic             clr,
  output logic [15:0]      err_total
);

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned TOT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  // One finished-frame result as held in the FIFO.
  typedef struct packed {
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             par;
    logic [CNT_W-1:0] len;
  } result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q, state_d;

  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               par_acc_q, par_acc_d;
  logic [CNT_W-1:0]   len_q, len_d;

  result_t            head_q, head_d;
  result_t            tail_q, tail_d;
  logic [PTR_W-1:0]   count_q, count_d;

  logic               out_valid_d;
  logic               in_ready_d;
  logic [TOT_W-1:0]   err_total_d;

  logic               accept_c;
  logic               pop_c;
  logic               push_c;
  logic               word_par_c;
  logic               word_err_c;
  logic [CNT_W-1:0]   err_base_c, err_nxt_c;
  logic               par_base_c, par_nxt_c;
  logic [CNT_W-1:0]   len_base_c, len_nxt_c;
  result_t            new_res_c;

  // Handshake qualifiers and per-word parity.
  always_comb begin
    accept_c   = in_valid & in_ready;
    pop_c      = out_valid & out_ready;
    push_c     = accept_c & in_last;
    word_par_c = ^in_data[DATA_W-1:0];
    word_err_c = word_par_c ^ in_par;
  end

  // Frame FSM next state: open on a non-last accept, close on a last accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c && !in_last) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator update: a new frame starts from zero, counters saturate.
  always_comb begin
    err_base_c = (state_q == ACCUM) ? err_cnt_q : '0;
    par_base_c = (state_q == ACCUM) ? par_acc_q : 1'b0;
    len_base_c = (state_q == ACCUM) ? len_q     : '0;

    err_nxt_c = err_base_c;
    if (word_err_c && (err_base_c != CNT_MAX)) begin
      err_nxt_c = err_base_c + CNT_W'(1);
    end
    len_nxt_c = len_base_c;
    if (len_base_c != CNT_MAX) begin
      len_nxt_c = len_base_c + CNT_W'(1);
    end
    par_nxt_c = par_base_c ^ word_par_c;

    new_res_c.err     = (err_nxt_c != '0);
    new_res_c.err_cnt = err_nxt_c;
    new_res_c.par     = par_nxt_c;
    new_res_c.len     = len_nxt_c;

    err_cnt_d = err_cnt_q;
    par_acc_d = par_acc_q;
    len_d     = len_q;
    if (accept_c) begin
      if (in_last) begin
        err_cnt_d = '0;
        par_acc_d = 1'b0;
        len_d     = '0;
      end else begin
        err_cnt_d = err_nxt_c;
        par_acc_d = par_nxt_c;
        len_d     = len_nxt_c;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      par_acc_q <= 1'b0;
      len_q     <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      par_acc_q <= par_acc_d;
      len_q     <= len_d;
    end
  end

  // Result FIFO as a two-stage shift queue so the head is always a register.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (count_q == '0) begin
          head_d = new_res_c;
        end else begin
          tail_d = new_res_c;
        end
        count_d = count_q + PTR_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - PTR_W'(1);
      end
      2'b11: begin
        // Push is only possible below full, so a concurrent pop leaves one entry.
        if (count_q == PTR_W'(1)) begin
          head_d = new_res_c;
        end else begin
          head_d = tail_q;
          tail_d = new_res_c;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d < PTR_W'(FIFO_DEPTH));
  end

  // FIFO storage and the handshake flags derived from its occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

  // Lifetime bad-word counter; clear wins over a coincident increment.
  always_comb begin
    err_total_d = err_total;
    if (clr) begin
      err_total_d = '0;
    end else if (accept_c && word_err_c && (err_total != TOT_MAX)) begin
      err_total_d = err_total + TOT_W'(1);
    end
  end

  // Lifetime counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_total <= '0;
    end else begin
      err_total <= err_total_d;
    end
  end

  // Result payload is the FIFO head register.
  assign out_err     = head_q.err;
  assign out_err_cnt = head_q.err_cnt;
  assign out_par     = head_q.par;
  assign out_len     = head_q.len;

endmodule

// File: tb/tb_parity_stream_check.sv
// Bench for parity_stream_check: directed scenarios plus a randomized run
// checked against a frame-level reference model.
module tb_parity_stream_check;

  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = 255;
  localparam int          TOT_MAX = 65535;
  localparam int unsigned PAY_W   = 2 * CNT_W + 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_par;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;
  logic [CNT_W-1:0] out_err_cnt;
  logic             out_par;
  logic [CNT_W-1:0] out_len;
  logic             clr;
  logic [15:0]      err_total;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int bad;
    int par;
    int len;
  } res_t;

  parity_stream_check #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .out_err_cnt(out_err_cnt), .out_par(out_par), .out_len(out_len),
    .clr(clr), .err_total(err_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [PAY_W-1:0] pay(input int bad, input int par, input int len);
    int b;
    int l;
    b = (bad > CNT_MAX) ? CNT_MAX : bad;
    l = (len > CNT_MAX) ? CNT_MAX : len;
    return {(b != 0), CNT_W'(b), 1'(par & 1), CNT_W'(l)};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
    out_ready = 1'b0; in_data = '0; in_par = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offers one word and waits (bounded) until it is accepted.
  task automatic drive_word(input logic [15:0] d, input logic p, input logic l);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; in_par = p; in_last = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL drive_word: in_ready=%b, required acceptance within 50 cycles", in_ready);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b0;
    in_data = '0; in_par = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    tests++;
    if ({out_err, out_err_cnt, out_par, out_len} !== '0) begin
      fails++; $display("FAIL reset_payload: got %h, required 0", {out_err, out_err_cnt, out_par, out_len});
    end
    tests++;
    if (err_total !== 16'h0) begin fails++; $display("FAIL reset_err_total: got %h, required 0", err_total); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    do_reset();
    drive_word(16'h0001, 1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b, required 1", out_valid); end
    tests++;
    if ({out_err, out_err_cnt, out_par, out_len} !== pay(0, 1, 1)) begin
      fails++; $display("FAIL single_payload: got %h, required %h", {out_err, out_err_cnt, out_par, out_len}, pay(0, 1, 1));
    end
    tests++;
    if (err_total !== 16'd0) begin fails++; $display("FAIL single_err_total: got %0d, required 0", err_total); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pop: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_multi_word();
    do_reset();
    drive_word(16'h00FF, 1'b0, 1'b0);
    drive_word(16'h0003, 1'b1, 1'b0);
    drive_word(16'h8000, 1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL multi_out_valid: got %b, required 1", out_valid); end
    tests++;
    if ({out_err, out_err_cnt, out_par, out_len} !== pay(1, 1, 3)) begin
      fails++; $display("FAIL multi_payload: got %h, required %h", {out_err, out_err_cnt, out_par, out_len}, pay(1, 1, 3));
    end
    tests++;
    if (err_total !== 16'd1) begin fails++; $display("FAIL multi_err_total: got %0d, required 1", err_total); end
  endtask

  task automatic test_back_to_back();
    logic [PAY_W-1:0] got [4];
    logic [PAY_W-1:0] exp [3];
    int n;
    bit acc_now;
    exp[0] = pay(0, 1, 1);
    exp[1] = pay(0, 0, 1);
    exp[2] = pay(1, 1, 1);
    do_reset();
    drive_word(16'h0001, 1'b1, 1'b1);
    drive_word(16'h0003, 1'b0, 1'b1);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_in_ready: got %b, required 0", in_ready); end
    in_valid = 1'b1; in_data = 16'h0007; in_par = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_hold: in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
      end
      tests++;
      if ({out_err, out_err_cnt, out_par, out_len} !== exp[0]) begin
        fails++; $display("FAIL b2b_stable: got %h, required %h", {out_err, out_err_cnt, out_par, out_len}, exp[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n < 4) got[n] = {out_err, out_err_cnt, out_par, out_len};
        n++;
      end
      acc_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    out_ready = 1'b0;
    tests++;
    if (n != 3) begin fails++; $display("FAIL b2b_count: got %0d results, required 3", n); end
    for (int i = 0; i < 3; i++) begin
      if (i < n) begin
        tests++;
        if (got[i] !== exp[i]) begin
          fails++; $display("FAIL b2b_order[%0d]: got %h, required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] d;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = 16'($urandom);
      drive_word(d, ~(^d), (i == 299));
    end
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL sat_out_valid: got %b, required 1", out_valid); end
    tests++;
    if (out_err_cnt !== 8'd255 || out_len !== 8'd255 || out_err !== 1'b1) begin
      fails++; $display("FAIL sat_counts: err_cnt=%0d len=%0d err=%b, required 255 255 1", out_err_cnt, out_len, out_err);
    end
    tests++;
    if (err_total !== 16'd300) begin fails++; $display("FAIL sat_err_total: got %0d, required 300", err_total); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive_word(16'h0001, 1'b1, 1'b1);
    drive_word(16'h0003, 1'b1, 1'b0);
    drive_word(16'h0001, 1'b0, 1'b0);
    tests++;
    if (err_total !== 16'd2) begin fails++; $display("FAIL midrst_pre_total: got %0d, required 2", err_total); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_err, out_err_cnt, out_par, out_len, err_total} !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_outputs: valid=%b pay=%h total=%h in_ready=%b, required 0 0 0 1",
                        out_valid, {out_err, out_err_cnt, out_par, out_len}, err_total, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_word(16'h0001, 1'b1, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || {out_err, out_err_cnt, out_par, out_len} !== pay(0, 1, 1)) begin
      fails++; $display("FAIL midrst_new_frame: valid=%b pay=%h, required 1 %h",
                        out_valid, {out_err, out_err_cnt, out_par, out_len}, pay(0, 1, 1));
    end
  endtask

  task automatic test_clr();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_word(16'h0001, 1'b0, 1'b1);
    tests++;
    if (err_total !== 16'd5) begin fails++; $display("FAIL clr_pre_total: got %0d, required 5", err_total); end
    clr = 1'b1;
    drive_word(16'h0001, 1'b0, 1'b1);
    clr = 1'b0;
    tests++;
    if (err_total !== 16'd0) begin fails++; $display("FAIL clr_priority: got %0d, required 0", err_total); end
    tests++;
    if (out_valid !== 1'b1 || out_err_cnt !== 8'd1) begin
      fails++; $display("FAIL clr_frame: valid=%b err_cnt=%0d, required 1 1", out_valid, out_err_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    res_t exp_q[$];
    res_t r;
    int m_total;
    int cur_bad, cur_par, cur_len;
    int qsize, bad, dpar;
    localparam int N = 2500;
    do_reset();
    m_total = 0; cur_bad = 0; cur_par = 0; cur_len = 0;
    for (int cyc = 0; cyc < N; cyc++) begin
      in_valid  = (cyc < N - 20) && ($urandom_range(9) < 7);
      in_data   = 16'($urandom);
      in_par    = 1'($urandom);
      in_last   = ($urandom_range(3) == 0);
      clr       = ($urandom_range(63) == 0);
      out_ready = (cyc >= N - 20) || ($urandom_range(2) != 0);
      @(negedge clk);
      qsize = exp_q.size();
      tests++;
      if (in_ready !== (qsize < 2) || out_valid !== (qsize != 0)) begin
        fails++; $display("FAIL rand_flags cyc %0d: in_ready=%b out_valid=%b, required %b %b",
                          cyc, in_ready, out_valid, (qsize < 2), (qsize != 0));
      end
      tests++;
      if (err_total !== 16'(m_total)) begin
        fails++; $display("FAIL rand_err_total cyc %0d: got %0d, required %0d", cyc, err_total, m_total);
      end
      if (qsize != 0) begin
        r = exp_q[0];
        tests++;
        if ({out_err, out_err_cnt, out_par, out_len} !== pay(r.bad, r.par, r.len)) begin
          fails++; $display("FAIL rand_payload cyc %0d: got %h, required %h",
                            cyc, {out_err, out_err_cnt, out_par, out_len}, pay(r.bad, r.par, r.len));
        end
      end
      // Model the upcoming edge.
      if (out_ready && qsize != 0) void'(exp_q.pop_front());
      dpar = $countones(in_data) % 2;
      bad  = (dpar + in_par) % 2;
      if (clr) m_total = 0;
      else if (in_valid && qsize < 2 && bad == 1 && m_total < TOT_MAX) m_total++;
      if (in_valid && qsize < 2) begin
        cur_bad += bad;
        cur_par ^= dpar;
        cur_len++;
        if (in_last) begin
          r.bad = cur_bad; r.par = cur_par; r.len = cur_len;
          exp_q.push_back(r);
          cur_bad = 0; cur_par = 0; cur_len = 0;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; clr = 1'b0;
    test_reset();
    test_single_word();
    test_multi_word();
    test_back_to_back();
    test_saturation();
    test_reset_midframe();
    test_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_stream_check.md
PARITY_STREAM_CHECK -- requirements
Module: parity_stream_check

Interface
REQ-001 Parameter: CNT_W, 8, width of per-frame error and length counters (>=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept a word.
REQ-006 in_data  input  16  data word.
REQ-007 in_par  input  1  transmitted parity bit (even parity over in_data plus in_par).
REQ-008 in_last  input  1  word is last of frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_err  output  1  frame contained at least one bad word.
REQ-012 out_err_cnt  output  CNT_W  bad words in frame, saturating.
REQ-013 out_par  output  1  XOR of all data bits of all words in frame (in_par excluded).
REQ-014 out_len  output  CNT_W  words in frame, saturating.
REQ-015 clr  input  1  synchronous clear of err_total.
REQ-016 err_total  output  16  lifetime bad-word count, saturating at 0xFFFF.

Function
REQ-017 Word accept SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_data/in_par/in_last are ignored otherwise.
REQ-018 Word error SHALL be e = XOR(in_data[15:0]) ^ in_par; e=1 marks a bad word.
REQ-019 Frame accumulators (err_cnt, par_acc, len) SHALL update on each accept: err_cnt += e, par_acc ^= XOR(in_data), len += 1; err_cnt and len SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 Frame FSM SHALL have states IDLE (no open frame) and ACCUM (open frame); IDLE->ACCUM on accept with in_last=0; ACCUM->IDLE on accept with in_last=1; IDLE->IDLE on accept with in_last=1 (single-word frame); otherwise hold.
REQ-021 On accept with in_last=1 the final values (including that word) SHALL be pushed into a 2-entry result FIFO and accumulators SHALL clear to 0 on the same edge.
REQ-022 Result latency: out_valid SHALL assert in the cycle after the closing accept when the FIFO was empty; out_* SHALL present the FIFO head.
REQ-023 in_ready SHALL be 1 iff FIFO count < 2, regardless of in_last or FSM state.
REQ-024 FIFO pop SHALL occur on an edge with out_valid=1 and out_ready=1; push and pop on the same edge with count=1 SHALL leave count=1 with the new entry at head.
REQ-025 out_* payload SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 out_err SHALL equal (out_err_cnt != 0) of the head entry.
REQ-027 err_total SHALL increment by e on each accept, saturating at 0xFFFF; clr=1 SHALL force err_total to 0 on that edge and take priority over a coincident increment.
REQ-028 FIFO entries SHALL be delivered in frame order; no entry SHALL be lost or duplicated.

Reset
REQ-029 While rst_n=0: FSM=IDLE, accumulators=0, FIFO empty, out_valid=0, out_err=0, out_err_cnt=0, out_par=0, out_len=0, err_total=0, in_ready=1.
REQ-030 Reset mid-frame SHALL discard the partial frame and any pending FIFO results; first accept after release starts a new frame from zero.

Verification
REQ-031 Single-word frame 0x0001, in_par=1, in_last=1 -> next cycle out_valid=1, out_err=0, out_err_cnt=0, out_par=1, out_len=1, err_total=0.
REQ-032 Frame 0x00FF/par0, 0x0003/par1, 0x8000/par1(last) -> out_err=1, out_err_cnt=1, out_par=1, out_len=3, err_total=1.
REQ-033 out_ready=0, three single-word frames offered back-to-back -> in_ready=0 after second result; third word held; raising out_ready pops results 1,2,3 in order with no loss.
REQ-034 CNT_W=8, 300-word frame all bad -> out_err_cnt=255, out_len=255, err_total=300.
REQ-035 Two words accepted then rst_n pulsed low -> all outputs zero, in_ready=1; next single-word frame reports out_len=1.
REQ-036 clr=1 on same edge as bad-word accept with err_total=5 -> err_total=0 next cycle.
